// File: rtl/text_writer.sv
// Writer side of the 80x25 text-mode screen RAM: consumes a character stream,
// keeps a cursor, handles CR/LF/BS/FF and clears the screen or a row when needed.
module text_writer #(
  parameter int         COLS       = 80,
  parameter int         ROWS       = 25,
  parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  char_i,
  input  logic        char_valid_i,
  output logic        char_ready_o,
  output logic [11:0] ram_addr_o,
  output logic [7:0]  ram_data_o,
  output logic        ram_wren_o,
  output logic [6:0]  cursor_x_o,
  output logic [4:0]  cursor_y_o
);

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  localparam logic [7:0] CODE_BS = 8'h08;
  localparam logic [7:0] CODE_LF = 8'h0A;
  localparam logic [7:0] CODE_FF = 8'h0C;
  localparam logic [7:0] CODE_CR = 8'h0D;

  typedef enum logic [1:0] {
    CLEAR_ALL,
    CLEAR_ROW,
    IDLE
  } state_t;

  state_t     state;
  logic [6:0] clr_col;
  logic [4:0] clr_row;
  logic [4:0] next_row;
  logic       handshake;

  assign next_row  = (cursor_y_o == LAST_ROW) ? 5'd0 : cursor_y_o + 5'd1;
  assign handshake = char_valid_i & char_ready_o;

  function automatic logic is_printable(input logic [7:0] c);
    return ((c >= 8'h20) && (c <= 8'h7E)) || (c >= 8'h80);
  endfunction

  // Ready is only ever raised by IDLE itself, so it first appears one cycle
  // after the final clear write; LF and FF issue their first clear write in the
  // handshake cycle so the clear starts without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= CLEAR_ALL;
      clr_col      <= 7'd0;
      clr_row      <= 5'd0;
      cursor_x_o   <= 7'd0;
      cursor_y_o   <= 5'd0;
      char_ready_o <= 1'b0;
      ram_wren_o   <= 1'b0;
      ram_addr_o   <= 12'd0;
      ram_data_o   <= 8'd0;
    end else begin
      ram_wren_o   <= 1'b0;
      char_ready_o <= 1'b0;
      case (state)
        CLEAR_ALL: begin
          ram_wren_o <= 1'b1;
          ram_addr_o <= {clr_row, clr_col};
          ram_data_o <= CLEAR_CHAR;
          if (clr_col == LAST_COL) begin
            clr_col <= 7'd0;
            if (clr_row == LAST_ROW) begin
              clr_row <= 5'd0;
              state   <= IDLE;
            end else begin
              clr_row <= clr_row + 5'd1;
            end
          end else begin
            clr_col <= clr_col + 7'd1;
          end
        end

        CLEAR_ROW: begin
          ram_wren_o <= 1'b1;
          ram_addr_o <= {cursor_y_o, clr_col};
          ram_data_o <= CLEAR_CHAR;
          if (clr_col == LAST_COL) begin
            clr_col <= 7'd0;
            state   <= IDLE;
          end else begin
            clr_col <= clr_col + 7'd1;
          end
        end

        IDLE: begin
          char_ready_o <= 1'b1;
          if (handshake) begin
            if (is_printable(char_i)) begin
              ram_wren_o <= 1'b1;
              ram_addr_o <= {cursor_y_o, cursor_x_o};
              ram_data_o <= char_i;
              if (cursor_x_o == LAST_COL) begin
                cursor_x_o   <= 7'd0;
                cursor_y_o   <= next_row;
                clr_col      <= 7'd0;
                char_ready_o <= 1'b0;
                state        <= CLEAR_ROW;
              end else begin
                cursor_x_o <= cursor_x_o + 7'd1;
              end
            end else begin
              case (char_i)
                CODE_CR: cursor_x_o <= 7'd0;
                CODE_LF: begin
                  cursor_x_o   <= 7'd0;
                  cursor_y_o   <= next_row;
                  ram_wren_o   <= 1'b1;
                  ram_addr_o   <= {next_row, 7'd0};
                  ram_data_o   <= CLEAR_CHAR;
                  clr_col      <= 7'd1;
                  char_ready_o <= 1'b0;
                  state        <= CLEAR_ROW;
                end
                CODE_BS: begin
                  if (cursor_x_o != 7'd0) begin
                    cursor_x_o <= cursor_x_o - 7'd1;
                    ram_wren_o <= 1'b1;
                    ram_addr_o <= {cursor_y_o, cursor_x_o - 7'd1};
                    ram_data_o <= CLEAR_CHAR;
                  end
                end
                CODE_FF: begin
                  cursor_x_o   <= 7'd0;
                  cursor_y_o   <= 5'd0;
                  ram_wren_o   <= 1'b1;
                  ram_addr_o   <= 12'd0;
                  ram_data_o   <= CLEAR_CHAR;
                  clr_col      <= 7'd1;
                  clr_row      <= 5'd0;
                  char_ready_o <= 1'b0;
                  state        <= CLEAR_ALL;
                end
                default: ;
              endcase
            end
          end
        end

        default: state <= CLEAR_ALL;
      endcase
    end
  end

endmodule

// File: tb/tb_text_writer.sv
// Directed self-checking bench for text_writer: screen clear, printing, wrap,
// control codes and reset during a form-feed clear.
module tb_text_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  char_i = 8'h00;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic [11:0] ram_addr;
  logic [7:0]  ram_data;
  logic        ram_wren;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;

  int n_cmp = 0;
  int n_err = 0;

  text_writer dut (
    .clk          (clk),
    .rst          (rst),
    .char_i       (char_i),
    .char_valid_i (char_valid),
    .char_ready_o (char_ready),
    .ram_addr_o   (ram_addr),
    .ram_data_o   (ram_data),
    .ram_wren_o   (ram_wren),
    .cursor_x_o   (cursor_x),
    .cursor_y_o   (cursor_y)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for ready, then performs one handshake; returns in cycle N+1.
  task automatic send(input logic [7:0] c);
    int t = 0;
    while (char_ready !== 1'b1 && t < 3000) begin
      step();
      t++;
    end
    if (t >= 3000) begin
      n_cmp++;
      n_err++;
      $display("[TB] FAIL ready_timeout: char_ready=%b required 1 before sending %h", char_ready, c);
    end
    char_i     = c;
    char_valid = 1'b1;
    step();
    char_valid = 1'b0;
  endtask

  // Entered in the first clear cycle; expects 2000 ordered writes then ready.
  task automatic expect_clear_all(input string name);
    int bad = 0;
    int first_bad = -1;
    logic [11:0] exp_addr;
    for (int r = 0; r < 25; r++) begin
      for (int c = 0; c < 80; c++) begin
        exp_addr = {5'(r), 7'(c)};
        if (ram_wren !== 1'b1 || ram_addr !== exp_addr || ram_data !== 8'h20 || char_ready !== 1'b0) begin
          if (first_bad < 0) begin
            first_bad = r * 80 + c;
            $display("[TB] %s first bad write #%0d: wren=%b addr=%h data=%h ready=%b required 1/%h/20/0",
                     name, first_bad, ram_wren, ram_addr, ram_data, char_ready, exp_addr);
          end
          bad++;
        end
        if (!(r == 24 && c == 79)) step();
      end
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("[TB] FAIL %s_writes: %0d bad of 2000, required 0", name, bad);
    end
    step();
    n_cmp++;
    if (char_ready !== 1'b1 || ram_wren !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL %s_done: ready=%b wren=%b required 1/0", name, char_ready, ram_wren);
    end
    n_cmp++;
    if (cursor_x !== 7'd0 || cursor_y !== 5'd0) begin
      n_err++;
      $display("[TB] FAIL %s_cursor: (%0d,%0d) required (0,0)", name, cursor_x, cursor_y);
    end
  endtask

  // Entered in the first row-clear cycle; expects 80 writes to row r then ready.
  task automatic expect_row_clear(input logic [4:0] r, input string name);
    int bad = 0;
    for (int c = 0; c < 80; c++) begin
      if (ram_wren !== 1'b1 || ram_addr !== {r, 7'(c)} || ram_data !== 8'h20 || char_ready !== 1'b0) begin
        if (bad == 0)
          $display("[TB] %s col %0d: wren=%b addr=%h data=%h ready=%b required 1/%h/20/0",
                   name, c, ram_wren, ram_addr, ram_data, char_ready, {r, 7'(c)});
        bad++;
      end
      if (c < 79) step();
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("[TB] FAIL %s_writes: %0d bad of 80, required 0", name, bad);
    end
    step();
    n_cmp++;
    if (char_ready !== 1'b1 || ram_wren !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL %s_done: ready=%b wren=%b required 1/0", name, char_ready, ram_wren);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_cmp++;
    if (char_ready !== 1'b0 || ram_wren !== 1'b0 || ram_addr !== 12'h000 || ram_data !== 8'h00 ||
        cursor_x !== 7'd0 || cursor_y !== 5'd0) begin
      n_err++;
      $display("[TB] FAIL reset_outputs: ready=%b wren=%b addr=%h data=%h cur=(%0d,%0d) required all zero",
               char_ready, ram_wren, ram_addr, ram_data, cursor_x, cursor_y);
    end
    rst = 1'b0;
    step();
    expect_clear_all("power_on_clear");
  endtask

  task automatic test_back_to_back();
    char_i = 8'h41;
    char_valid = 1'b1;
    step();
    n_cmp++;
    if (ram_wren !== 1'b1 || ram_addr !== 12'h000 || ram_data !== 8'h41 || char_ready !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL b2b_A: wren=%b addr=%h data=%h ready=%b required 1/000/41/1", ram_wren, ram_addr, ram_data, char_ready);
    end
    char_i = 8'h42;
    step();
    char_valid = 1'b0;
    n_cmp++;
    if (ram_wren !== 1'b1 || ram_addr !== 12'h001 || ram_data !== 8'h42 || char_ready !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL b2b_B: wren=%b addr=%h data=%h ready=%b required 1/001/42/1", ram_wren, ram_addr, ram_data, char_ready);
    end
    n_cmp++;
    if (cursor_x !== 7'd2 || cursor_y !== 5'd0) begin
      n_err++;
      $display("[TB] FAIL b2b_cursor: (%0d,%0d) required (2,0)", cursor_x, cursor_y);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] ch;
    send(8'h0D);
    n_cmp++;
    if (ram_wren !== 1'b0 || cursor_x !== 7'd0 || cursor_y !== 5'd0 || char_ready !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL cr_row0: wren=%b cur=(%0d,%0d) ready=%b required 0/(0,0)/1", ram_wren, cursor_x, cursor_y, char_ready);
    end
    for (int i = 0; i < 79; i++) send(8'h61 + 8'(i % 26));
    ch = 8'h61 + 8'(79 % 26);
    send(ch);
    n_cmp++;
    if (ram_wren !== 1'b1 || ram_addr !== 12'h04F || ram_data !== ch || char_ready !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL wrap_80th: wren=%b addr=%h data=%h ready=%b required 1/04f/%h/0", ram_wren, ram_addr, ram_data, char_ready, ch);
    end
    n_cmp++;
    if (cursor_x !== 7'd0 || cursor_y !== 5'd1) begin
      n_err++;
      $display("[TB] FAIL wrap_cursor: (%0d,%0d) required (0,1)", cursor_x, cursor_y);
    end
    step();
    expect_row_clear(5'd1, "wrap_clear");
    send(8'h5A);
    n_cmp++;
    if (ram_wren !== 1'b1 || ram_addr !== 12'h080 || ram_data !== 8'h5A || cursor_x !== 7'd1 || cursor_y !== 5'd1) begin
      n_err++;
      $display("[TB] FAIL wrap_81st: wren=%b addr=%h data=%h cur=(%0d,%0d) required 1/080/5a/(1,1)",
               ram_wren, ram_addr, ram_data, cursor_x, cursor_y);
    end
  endtask

  task automatic test_bs_and_other();
    send(8'h0A);
    expect_row_clear(5'd2, "lf_row2");
    send(8'h78); send(8'h79); send(8'h7A);
    send(8'h08);
    n_cmp++;
    if (ram_wren !== 1'b1 || ram_addr !== 12'h102 || ram_data !== 8'h20 || cursor_x !== 7'd2 || cursor_y !== 5'd2) begin
      n_err++;
      $display("[TB] FAIL bs_mid: wren=%b addr=%h data=%h cur=(%0d,%0d) required 1/102/20/(2,2)",
               ram_wren, ram_addr, ram_data, cursor_x, cursor_y);
    end
    send(8'h0D);
    send(8'h08);
    n_cmp++;
    if (ram_wren !== 1'b0 || cursor_x !== 7'd0 || cursor_y !== 5'd2) begin
      n_err++;
      $display("[TB] FAIL bs_col0: wren=%b cur=(%0d,%0d) required 0/(0,2)", ram_wren, cursor_x, cursor_y);
    end
    send(8'h07);
    n_cmp++;
    if (ram_wren !== 1'b0 || cursor_x !== 7'd0 || cursor_y !== 5'd2 || char_ready !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL bell: wren=%b cur=(%0d,%0d) ready=%b required 0/(0,2)/1", ram_wren, cursor_x, cursor_y, char_ready);
    end
  endtask

  task automatic test_cr();
    send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h30 + 8'(i));
    send(8'h0D);
    n_cmp++;
    if (ram_wren !== 1'b0 || cursor_x !== 7'd0 || cursor_y !== 5'd3) begin
      n_err++;
      $display("[TB] FAIL cr_row3: wren=%b cur=(%0d,%0d) required 0/(0,3)", ram_wren, cursor_x, cursor_y);
    end
  endtask

  task automatic test_lf_wrap();
    for (int i = 0; i < 21; i++) send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h2E);
    n_cmp++;
    if (cursor_x !== 7'd5 || cursor_y !== 5'd24) begin
      n_err++;
      $display("[TB] FAIL pre_lf_cursor: (%0d,%0d) required (5,24)", cursor_x, cursor_y);
    end
    send(8'h0A);
    n_cmp++;
    if (cursor_x !== 7'd0 || cursor_y !== 5'd0) begin
      n_err++;
      $display("[TB] FAIL lf_wrap_cursor: (%0d,%0d) required (0,0)", cursor_x, cursor_y);
    end
    expect_row_clear(5'd0, "lf_wrap_clear");
  endtask

  task automatic test_ff_reset();
    int bad = 0;
    send(8'h41);
    send(8'h0C);
    n_cmp++;
    if (ram_wren !== 1'b1 || ram_addr !== 12'h000 || cursor_x !== 7'd0 || char_ready !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL ff_start: wren=%b addr=%h cur_x=%0d ready=%b required 1/000/0/0", ram_wren, ram_addr, cursor_x, char_ready);
    end
    for (int i = 0; i < 500; i++) begin
      step();
      if (ram_wren !== 1'b1 || char_ready !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("[TB] FAIL ff_progress: %0d bad cycles, required 0", bad);
    end
    rst = 1'b1;
    step();
    n_cmp++;
    if (ram_wren !== 1'b0 || ram_addr !== 12'h000 || ram_data !== 8'h00 || char_ready !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL mid_clear_reset: wren=%b addr=%h data=%h ready=%b required 0/000/00/0", ram_wren, ram_addr, ram_data, char_ready);
    end
    rst = 1'b0;
    step();
    expect_clear_all("restarted_clear");
  endtask

  initial begin
    $display("[TB] text_writer directed test start");
    test_reset();
    test_back_to_back();
    test_wrap();
    test_bs_and_other();
    test_cr();
    test_lf_wrap();
    test_ff_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/text_writer.md
Name: text_writer

Overview:
- Writer side of the 80x25 text-mode screen RAM; the display pipeline is the reader of the same RAM.
- Accepts a byte stream of characters with a valid/ready handshake and keeps a cursor.
- Interprets a small set of control codes.
- Drives the screen RAM write port: address = {row[4:0], col[6:0]}, 8-bit character data, write enable.

Parameters:
- COLS, 80, visible columns per row; column counter is 7 bits.
- ROWS, 25, visible rows; row counter is 5 bits.
- CLEAR_CHAR, 8'h20, code written by clear operations and backspace.

Ports:
- clk  in  1  system clock, same clock as the screen RAM port.
- rst  in  1  synchronous, active-high reset.
- char_i  in  8  incoming character code.
- char_valid_i  in  1  char_i is valid.
- char_ready_o  out  1  block can accept a character this cycle.
- ram_addr_o  out  12  screen RAM address: [6:0] = column, [11:7] = row.
- ram_data_o  out  8  screen RAM write data.
- ram_wren_o  out  1  screen RAM write enable, one write per asserted cycle.
- cursor_x_o  out  7  current cursor column, 0..COLS-1.
- cursor_y_o  out  5  current cursor row, 0..ROWS-1.

Behaviour:
- One clock. Reset is synchronous and active-high. All outputs are registered.
- While rst=1, outputs are: char_ready_o=0, ram_wren_o=0, ram_addr_o=0, ram_data_o=0, cursor=(0,0). State goes to CLEAR_ALL with the clear pointer at (0,0).
- rst asserted in any state, including mid-clear, aborts the operation. A full CLEAR_ALL restarts after release.
- States: CLEAR_ALL, CLEAR_ROW, IDLE.
- CLEAR_ALL:
  - Writes CLEAR_CHAR with ram_wren_o=1 every cycle.
  - Order: column 0..COLS-1 within row, rows 0..ROWS-1: ROWS*COLS cycles (2000 by default).
  - First write is in the first cycle after rst deasserts.
  - Next state is IDLE; char_ready_o=1 in the cycle after the last write.
- CLEAR_ROW:
  - Writes CLEAR_CHAR to columns 0..COLS-1 of cursor_y_o, one per cycle (80 cycles).
  - Then goes to IDLE.
- char_ready_o=1 only in IDLE. A handshake is char_valid_i & char_ready_o in cycle N; the effect appears at N+1.
- Columns COLS..127 are never written.
- Printable char (0x20..0x7E, 0x80..0xFF):
  - At N+1: ram_wren_o=1, address = cursor at N, ram_data_o = char_i.
  - At N+1 the cursor advances col+1.
  - If col was COLS-1:
    - col<=0, and row<=row+1, wrapping ROWS-1 to 0.
    - The N+1 cycle still performs the character write. char_ready_o=0 from N+1.
    - CLEAR_ROW on the new row runs N+2..N+1+COLS; char_ready_o=1 at N+2+COLS.
  - Otherwise char_ready_o stays 1, so back-to-back chars give one write per cycle.
- 0x0D (CR): col<=0, no write, ready stays 1.
- 0x0A (LF):
  - col<=0, row<=row+1, wrapping ROWS-1 to 0.
  - CLEAR_ROW writes the new row N+1..N+COLS; char_ready_o=0 for those cycles and =1 at N+COLS+1.
- 0x08 (BS):
  - If col>0: col<=col-1 and write CLEAR_CHAR at (row, col-1) at N+1.
  - If col=0: no-op, with no reverse wrap to the previous row.
- 0x0C (FF): cursor<=(0,0); CLEAR_ALL runs N+1..N+ROWS*COLS.
- Other codes (0x00..0x1F not listed, 0x7F): consumed, no write, no cursor change.
- When ram_wren_o=0, ram_addr_o and ram_data_o hold their last values; they are don't-care to the RAM.
- char_i is sampled only on a handshake. While ready=0 the input must be held by the source and is not consumed.

Test Plan:
- Release rst → ram_wren_o=1 for exactly 2000 consecutive cycles, addresses walking 0x000..0x04F, 0x080..0x0CF, …, 0xC00..0xC4F, data 0x20 throughout. char_ready_o rises the cycle after the last write; cursor reads (0,0).
- Stream "AB" back-to-back from IDLE → writes 0x41@0x000 then 0x42@0x001 in consecutive cycles, char_ready_o stays 1, cursor ends at (2,0).
- Send 80 printable chars, then one more → the 80th is written @0x04F, then 80 writes of 0x20 to 0x080..0x0CF with ready=0, then the 81st char is written @0x080 and cursor reads (1,1).
- Cursor (5,24), send LF → 80 clears to 0xC00..0xC4F? No: clears go to row 0, addresses 0x000..0x04F; cursor reads (0,0). Cursor (5,3), send CR → no write, cursor reads (0,3).
- Cursor (3,2), send BS → one write of 0x20 @0x102, cursor reads (2,2). At cursor (0,2), BS → no write, cursor unchanged. Send 0x07 → consumed, no write.
- Assert rst for 1 cycle midway through a 0x0C clear → the clear restarts at 0x000 and completes the full 2000 writes; ready is 0 until done.
